// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int              DEF_ADDR_W      = 8;
    localparam int              DEF_INSTR_W     = 8;
    localparam logic [7:0]      DEF_HALT_OPCODE = 8'hFF;
    localparam int              FETCH_CNT_W     = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] value);
        if (value == {FETCH_CNT_W{1'b1}}) begin
            return value;
        end
        return value + FETCH_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, addresses the instruction memory,
// and hands each fetched word plus its PC to decode over valid/ready.
// Supports branch redirects, halt-on-opcode, start/resume and single-step.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                   ADDR_W      = DEF_ADDR_W,
    parameter int                   INSTR_W     = DEF_INSTR_W,
    parameter int                   MEM_DEPTH   = 32,
    parameter int                   RESET_PC    = 0,
    parameter logic [INSTR_W-1:0]   HALT_OPCODE = INSTR_W'(DEF_HALT_OPCODE)
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    step_mode,
    input  logic                    step,
    output logic [ADDR_W-1:0]       imem_address,
    input  logic [INSTR_W-1:0]      imem_instruction,
    output logic [INSTR_W-1:0]      instr_out,
    output logic [ADDR_W-1:0]       instr_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_target,
    output logic                    halted,
    output logic [FETCH_CNT_W-1:0]  fetch_count
);

    // MEM_DEPTH is a power of two, so the wrap is a simple mask.
    localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC % MEM_DEPTH);

    fetch_state_t               state_reg;
    logic                       halted_reg;
    logic [ADDR_W-1:0]          pc_reg;
    logic [INSTR_W-1:0]         instr_reg;
    logic [ADDR_W-1:0]          instr_pc_reg;
    logic                       instr_valid_reg;
    logic                       step_pending_reg;
    logic [FETCH_CNT_W-1:0]     fetch_count_reg;

    logic                       transfer;
    logic                       slot_free;
    logic                       step_ok;
    logic                       fetch_en;
    logic                       fetch_is_halt;
    logic                       flush;
    logic [ADDR_W-1:0]          pc_inc;
    logic [ADDR_W-1:0]          redirect_pc;

    // Handshake, fetch qualification and next-PC candidates
    always_comb begin
        transfer      = instr_valid_reg & instr_ready;
        slot_free     = ~instr_valid_reg | instr_ready;
        // In single-step mode a fetch needs a remembered or same-cycle step
        step_ok       = ~step_mode | step_pending_reg | step;
        fetch_en      = (state_reg == RUN) & ~redirect_valid & slot_free & step_ok;
        fetch_is_halt = (imem_instruction == HALT_OPCODE);
        // A redirect in IDLE only moves the PC; elsewhere it also drops the slot
        flush         = redirect_valid & (state_reg != IDLE);
        pc_inc        = (pc_reg + ADDR_W'(1)) & PC_MASK;
        redirect_pc   = redirect_target & PC_MASK;
    end

    // Control FSM; halted is registered alongside the state it mirrors
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg  <= IDLE;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= RUN;
                        halted_reg <= 1'b0;
                    end
                end
                RUN: begin
                    // The halt word itself is still delivered by the slot logic
                    if (fetch_en && fetch_is_halt) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                HALTED: begin
                    // Resume at the current PC, which a same-cycle redirect may move
                    if (start) begin
                        state_reg  <= RUN;
                        halted_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    // Program counter: redirect wins over sequential advance
    always_ff @(posedge clk) begin
        if (clear) begin
            pc_reg <= PC_RESET;
        end else if (redirect_valid) begin
            pc_reg <= redirect_pc;
        end else if (fetch_en) begin
            pc_reg <= pc_inc;
        end
    end

    // Output slot: load on fetch, flush on redirect, empty when drained
    always_ff @(posedge clk) begin
        if (clear) begin
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
        end else if (flush) begin
            instr_valid_reg <= 1'b0;
        end else if (fetch_en) begin
            instr_reg       <= imem_instruction;
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
        end else if (slot_free) begin
            instr_valid_reg <= 1'b0;
        end
    end

    // Step request latch so a step during backpressure is not lost
    always_ff @(posedge clk) begin
        if (clear) begin
            step_pending_reg <= 1'b0;
        end else if (step_mode) begin
            if (fetch_en) begin
                step_pending_reg <= 1'b0;
            end else if (step) begin
                step_pending_reg <= 1'b1;
            end
        end
    end

    // Delivered-instruction counter, saturating; counts even during a redirect
    always_ff @(posedge clk) begin
        if (clear) begin
            fetch_count_reg <= '0;
        end else if (transfer) begin
            fetch_count_reg <= sat_inc(fetch_count_reg);
        end
    end

    assign imem_address = pc_reg;
    assign instr_out    = instr_reg;
    assign instr_pc     = instr_pc_reg;
    assign instr_valid  = instr_valid_reg;
    assign halted       = halted_reg;
    assign fetch_count  = fetch_count_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  imem_address;
    logic [7:0]  imem_instruction;
    logic [7:0]  instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = 8'd0;
    logic        halted;
    logic [15:0] fetch_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:31];

    // Reference model state
    int         m_pc, m_state, m_count;    // m_state: 0 idle, 1 run, 2 halted
    bit         m_pend, m_valid;
    logic [7:0] m_instr;
    int         m_ipc;

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_address[4:0]];

    fetch_controller dut (
        .clk(clk), .clear(clear), .start(start), .step_mode(step_mode), .step(step),
        .imem_address(imem_address), .imem_instruction(imem_instruction),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halted(halted), .fetch_count(fetch_count)
    );

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        bit xfer, free, fe;
        int st0;
        if (clear) begin
            m_pc = 0; m_state = 0; m_count = 0; m_pend = 0;
            m_valid = 0; m_instr = 8'h00; m_ipc = 0;
            return;
        end
        st0  = m_state;
        xfer = m_valid && instr_ready;
        free = !m_valid || instr_ready;
        fe   = (st0 == 1) && !redirect_valid && free && (!step_mode || m_pend || step);
        if (xfer) begin
            $display("xfer pc=%0d instr=%02h", m_ipc, m_instr);
            if (m_count < 65535) m_count++;
        end
        if (fe) begin
            m_instr = mem[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            if (mem[m_pc] == 8'hFF) m_state = 2;
            m_pc = (m_pc + 1) % 32;
        end else if (redirect_valid && st0 != 0) begin
            m_valid = 0;
        end else if (free) begin
            m_valid = 0;
        end
        if (redirect_valid) m_pc = int'(redirect_target) % 32;
        if (step_mode) begin
            if (fe) m_pend = 0;
            else if (step) m_pend = 1;
        end
        if (start && st0 != 1) m_state = 1;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image();
        for (int i = 0; i < 32; i++) begin
            if (i < 8) mem[i] = 8'hC1;
            else if (i < 10) mem[i] = 8'hC3;
            else if (i == 10) mem[i] = 8'hFF;
            else mem[i] = 8'(8'h10 + i);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        checks++; if (imem_address !== 8'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", imem_address); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fetch_count); end
        checks++; if (instr_out !== 8'd0 || instr_pc !== 8'd0) begin errors++; $display("FAIL reset_slot got=%02h/%0d want=00/0", instr_out, instr_pc); end
    endtask

    task automatic test_straight_line();
        logic [7:0] want;
        instr_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            want = (k < 8) ? 8'hC1 : (k < 10) ? 8'hC3 : 8'hFF;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr_out !== want) begin
                errors++;
                $display("FAIL line_fetch%0d got v=%b pc=%0d i=%02h want v=1 pc=%0d i=%02h", k, instr_valid, instr_pc, instr_out, k, want);
            end
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL line_halt got=%b want=1", halted); end
        tick();
        checks++; if (fetch_count !== 16'd11) begin errors++; $display("FAIL line_count got=%0d want=11", fetch_count); end
        checks++; if (imem_address !== 8'd11) begin errors++; $display("FAIL line_addr got=%0d want=11", imem_address); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL line_drained got=%b want=0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL line_stay_halted got v=%b h=%b want v=0 h=1", instr_valid, halted); end
    endtask

    task automatic test_resume();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_halted got=%b want=0", halted); end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'd11 || instr_out !== mem[11]) begin
            errors++;
            $display("FAIL resume_pc got v=%b pc=%0d i=%02h want v=1 pc=11 i=%02h", instr_valid, instr_pc, instr_out, mem[11]);
        end
        tick();
    endtask

    task automatic test_clear();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL clear_pre got=%b want=1", instr_valid); end
        do_clear();
        checks++;
        if (instr_valid !== 1'b0 || imem_address !== 8'd0 || fetch_count !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid_run got v=%b a=%0d c=%0d h=%b want 0/0/0/0", instr_valid, imem_address, fetch_count, halted);
        end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL clear_idle got=%b want=0", instr_valid); end
    endtask

    task automatic test_backpressure();
        do_clear();
        instr_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 8'hC1 || instr_pc !== 8'd0 || imem_address !== 8'd1 || fetch_count !== 16'd0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b i=%02h pc=%0d a=%0d c=%0d want 1/C1/0/1/0", c, instr_valid, instr_out, instr_pc, imem_address, fetch_count);
            end
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (instr_pc !== 8'd1 || instr_valid !== 1'b1 || fetch_count !== 16'd1) begin
            errors++;
            $display("FAIL bp_release got pc=%0d v=%b c=%0d want 1/1/1", instr_pc, instr_valid, fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_clear();
        instr_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        checks++; if (instr_pc !== 8'd3 || instr_valid !== 1'b1) begin errors++; $display("FAIL redir_setup got pc=%0d v=%b want 3/1", instr_pc, instr_valid); end
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'd8;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        checks++;
        if (instr_valid !== 1'b0 || fetch_count !== 16'd3 || imem_address !== 8'd8) begin
            errors++;
            $display("FAIL redir_flush got v=%b c=%0d a=%0d want 0/3/8", instr_valid, fetch_count, imem_address);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'd8 || instr_out !== 8'hC3) begin
            errors++;
            $display("FAIL redir_target got v=%b pc=%0d i=%02h want 1/8/C3", instr_valid, instr_pc, instr_out);
        end
        redirect_valid = 1'b1; redirect_target = 8'h25;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_address !== 8'd5) begin errors++; $display("FAIL redir_wrap got=%0d want=5", imem_address); end
        checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL redir_count got=%0d want=4", fetch_count); end
    endtask

    task automatic test_single_step();
        int nd;
        int pcs [4];
        do_clear();
        step_mode = 1'b1; instr_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        nd = 0;
        for (int c = 0; c < 16; c++) begin
            step = (c == 5 || c == 12);
            tick();
            if (instr_valid === 1'b1) begin
                if (nd < 4) pcs[nd] = int'(instr_pc);
                nd++;
            end
        end
        step = 1'b0;
        checks++; if (nd != 2) begin errors++; $display("FAIL step_count got=%0d want=2", nd); end
        checks++; if (nd >= 2 && (pcs[0] != 0 || pcs[1] != 1)) begin errors++; $display("FAIL step_pcs got=%0d,%0d want=0,1", pcs[0], pcs[1]); end
        step = 1'b1; tick(); step = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd2) begin errors++; $display("FAIL step_third got v=%b pc=%0d want 1/2", instr_valid, instr_pc); end
        instr_ready = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd2) begin errors++; $display("FAIL step_blocked got v=%b pc=%0d want 1/2", instr_valid, instr_pc); end
        instr_ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd3) begin errors++; $display("FAIL step_remembered got v=%b pc=%0d want 1/3", instr_valid, instr_pc); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL step_consumed got=%b want=0", instr_valid); end
        step_mode = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        do_clear();
        for (int c = 0; c < 600; c++) begin
            clear           = ($urandom_range(0, 99) == 0);
            start           = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) step_mode = ~step_mode;
            step            = ($urandom_range(0, 3) == 0);
            instr_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid  = ($urandom_range(0, 15) == 0);
            redirect_target = 8'($urandom_range(0, 255));
            tick();
            checks++;
            if (instr_valid !== m_valid || imem_address !== 8'(m_pc) || halted !== (m_state == 2) ||
                fetch_count !== 16'(m_count) || (m_valid && (instr_out !== m_instr || instr_pc !== 8'(m_ipc)))) begin
                errors++;
                $display("FAIL rand_cycle%0d got v=%b a=%0d h=%b c=%0d i=%02h pc=%0d want v=%b a=%0d h=%b c=%0d i=%02h pc=%0d",
                         c, instr_valid, imem_address, halted, fetch_count, instr_out, instr_pc,
                         m_valid, m_pc, (m_state == 2), m_count, m_instr, m_ipc);
            end
            checks++;
            if (imem_address >= 8'd32) begin errors++; $display("FAIL rand_range%0d got=%0d want<32", c, imem_address); end
        end
        clear = 1'b0; start = 1'b0; step = 1'b0; redirect_valid = 1'b0; step_mode = 1'b0;
    endtask

    initial begin
        load_image();
        test_reset();
        test_straight_line();
        test_resume();
        test_clear();
        test_backpressure();
        test_redirect();
        test_single_step();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
